lenet_layer_sequencer: RTL and testbench
========================================

# lenet_layer_sequencer

Top-level control FSM for the LeNet accelerator datapath. Accepts a single `start` from the host and fires each layer engine (conv1, conv2, conv3, fully-connected) in order, waiting on each engine's `done` before moving on. After the FC layer it runs a serial argmax over the 10 class scores and reports the winning class. It sits between the host/bench and the `Lenet_accelerator` layer engines and owns no arithmetic beyond the argmax compare.

## Interface
- `bitwidth`, 9, datapath element width; scores are `bitwidth+8` bits signed.
- `NUM_CLASSES`, 10, number of FC outputs scanned by argmax.
- `TIMEOUT`, 4096, per-stage watchdog limit in cycles (used only when `LENET_SEQ_TIMEOUT_EN` is defined).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request one inference; sampled only in IDLE.
- `busy` out 1: high in states C1, C2, C3, FC and ARGMAX.
- `done` out 1: one-cycle pulse at the end of a run.
- `error` out 1: watchdog abort flag; sticky.
- `class_id` out 4: winning class index.
- `class_score` out `bitwidth+8` signed: winning score.
- `conv1_start`, `conv2_start`, `conv3_start`, `fc_start` out 1 each: one-cycle stage kick.
- `conv1_done`, `conv2_done`, `conv3_done`, `fc_done` in 1 each: stage completion, level or pulse.
- `score_sel` out 4: index into the FC `output_vector`.
- `score_in` in `bitwidth+8` signed: `output_vector[score_sel]`, driven combinationally by the external mux in the same cycle.

## Operation
- States and transitions:
  - IDLE → C1 when `start`=1. All other IDLE cycles stay in IDLE.
  - C1 → C2 → C3 → FC, each on the corresponding `*_done`.
  - FC → ARGMAX on `fc_done`.
  - ARGMAX → DONE after index `NUM_CLASSES-1` is sampled.
  - DONE → IDLE unconditionally.
- Stage kick: `xx_start` is high only in the first cycle of state xx. `xx_done` is ignored in that cycle and sampled from the following cycle onward, so a stale `done` left over from a previous run cannot advance the FSM.
- ARGMAX:
  - `score_sel` steps 0..`NUM_CLASSES-1`, one index per cycle; `score_in` is sampled each cycle.
  - Index 0 initialises the best score and index.
  - For later indices, best is replaced only if `score_in` > best, using a signed, strict compare. Ties therefore resolve to the lowest index.
- `class_id` and `class_score` load from the best registers on DONE entry and hold until the next successful DONE.
- `score_sel` is 0 outside ARGMAX.
- `start` in any state other than IDLE (including DONE) is ignored; it is not queued.
- `done` is asserted in the DONE state only.
- Reset values: state=IDLE; `busy`, `done`, `error`, all `*_start`, `class_id`, `class_score`, `score_sel` = 0.
- `rst` mid-run returns to IDLE at the next edge. No `*_start` pulse is issued in that cycle, and stage engines are not otherwise notified.

## Timing
- `start` is sampled at edge 0, so C1 is entered in cycle 1 and `conv1_start` is high in cycle 1.
- Let stage k assert `done` d_k cycles after its kick (d_k ≥ 1). Then:
  - FC is entered in cycle 4+d1+d2+d3.
  - ARGMAX occupies cycles 5+Σd through 14+Σd.
  - `done` pulses in cycle 15+Σd.
- IDLE is re-entered the cycle after `done`; a new `start` is accepted there, giving back-to-back runs with a one-cycle gap.
- `busy` falls in the same cycle `done` rises.

## Configuration
- `LENET_SEQ_TIMEOUT_EN` defined:
  - A per-stage counter clears on entry to C1, C2, C3 or FC.
  - If `TIMEOUT` cycles elapse in a stage with no `done` seen, the FSM jumps to DONE, `done` pulses, and `error` is set.
  - `class_id` and `class_score` keep their previous values (no load on an aborted run).
  - `error` stays high until the next accepted `start` or `rst`.
- `LENET_SEQ_TIMEOUT_EN` undefined: no counter is built; stages wait indefinitely; `error` is tied to 0.

## Test plan
- Basic run: every stage's `done` is high one cycle after its kick (d=1), scores = {-5,3,9,9,0,-256,1,2,8,7}. Expect `done` in cycle 19, `class_id`=2 (tie with index 3 goes to the lower index), `class_score`=9.
- Varying latency: d1=7, d2=3, d3=12, d4=5. Expect each kick exactly one cycle after the previous `done`, and `done` in cycle 42.
- Stale done and ignored start: hold all `*_done`=1 continuously. Expect each stage to advance only in the cycle after its kick. Assert `start` while busy and in the DONE cycle; expect no second run.
- All-negative scores: all scores = -65536 except index 9 = -65535. Expect `class_id`=9, `class_score`=-65535.
- Reset mid-run: assert `rst` during C3. Expect IDLE next cycle and every output 0. A fresh run afterwards must complete normally.
- Timeout (built with `LENET_SEQ_TIMEOUT_EN`, `TIMEOUT`=16): `conv2_done` never asserts. Expect `done` and `error` in cycle 19, `class_id` unchanged, and `error` cleared by the next `start`.

Source files
------------

// File: rtl/lenet_layer_sequencer.sv
// lenet_layer_sequencer
//   Top-level control FSM for the LeNet datapath. One host `start` kicks
//   conv1, conv2, conv3 and fc in order, waiting on each engine's done, then
//   scans the FC output vector with a serial argmax and reports the winner.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    host request (sampled in IDLE only)
//   busy, done, error        status (done = one-cycle end-of-run pulse)
//   class_id, class_score    winning class and score, held between runs
//   convN_start / fc_start   one-cycle stage kicks
//   convN_done  / fc_done    stage completion (level or pulse)
//   score_sel, score_in      argmax index out, selected FC score in (same cycle)
//
// Optional feature: define LENET_SEQ_TIMEOUT_EN to build a per-stage watchdog
// of TIMEOUT cycles that aborts the run and sets a sticky `error`.
module lenet_layer_sequencer #(
  parameter int bitwidth    = 9,
  parameter int NUM_CLASSES = 10,
  parameter int TIMEOUT     = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [3:0]                 class_id,
  output logic signed [bitwidth+7:0] class_score,
  output logic                       conv1_start,
  output logic                       conv2_start,
  output logic                       conv3_start,
  output logic                       fc_start,
  input  logic                       conv1_done,
  input  logic                       conv2_done,
  input  logic                       conv3_done,
  input  logic                       fc_done,
  output logic [3:0]                 score_sel,
  input  logic signed [bitwidth+7:0] score_in
);
  localparam int SW = bitwidth + 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_C1   = 3'd1;
  localparam logic [2:0] S_C2   = 3'd2;
  localparam logic [2:0] S_C3   = 3'd3;
  localparam logic [2:0] S_FC   = 3'd4;
  localparam logic [2:0] S_ARG  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]          state, nxt_stage;
  logic                first;      // first cycle of a stage: kick out, done ignored
  logic                in_stage, stage_done, advance, upd, timeout_hit;
  logic [3:0]          idx, best_idx;
  logic signed [SW-1:0] best_score;

  always_comb begin
    stage_done = 1'b0;
    nxt_stage  = S_IDLE;
    case (state)
      S_C1:    begin stage_done = conv1_done; nxt_stage = S_C2;  end
      S_C2:    begin stage_done = conv2_done; nxt_stage = S_C3;  end
      S_C3:    begin stage_done = conv3_done; nxt_stage = S_FC;  end
      S_FC:    begin stage_done = fc_done;    nxt_stage = S_ARG; end
      default: ;
    endcase
  end

  assign in_stage = (state == S_C1) || (state == S_C2) || (state == S_C3) || (state == S_FC);
  // Masking done in the kick cycle keeps a stale done from a previous run out.
  assign advance  = in_stage && !first && stage_done;
  // Index 0 seeds the best registers; later indices need a strict win so ties
  // stay with the lower index.
  assign upd      = (idx == 4'd0) || (score_in > best_score);

  assign busy        = in_stage || (state == S_ARG);
  assign done        = (state == S_DONE);
  assign conv1_start = (state == S_C1) && first;
  assign conv2_start = (state == S_C2) && first;
  assign conv3_start = (state == S_C3) && first;
  assign fc_start    = (state == S_FC) && first;
  assign score_sel   = (state == S_ARG) ? idx : 4'd0;

`ifdef LENET_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic          err_q;
  logic          entering;

  assign entering    = ((state == S_IDLE) && start) || (advance && (state != S_FC));
  // tcnt is 0 in a stage's first cycle, so TIMEOUT cycles elapse at TIMEOUT-1.
  assign timeout_hit = in_stage && !advance && (tcnt == TW'(TIMEOUT - 1));
  assign error       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt <= entering ? '0 : tcnt + TW'(1);
      if ((state == S_IDLE) && start) err_q <= 1'b0;
      else if (timeout_hit)            err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      first       <= 1'b0;
      idx         <= 4'd0;
      best_idx    <= 4'd0;
      best_score  <= '0;
      class_id    <= 4'd0;
      class_score <= '0;
    end else begin
      first <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_C1;
          first <= 1'b1;
        end
        S_C1, S_C2, S_C3, S_FC: begin
          if (advance) begin
            state <= nxt_stage;
            first <= 1'b1;
            idx   <= 4'd0;
          end else if (timeout_hit) begin
            state <= S_DONE;       // aborted run: class outputs keep old values
          end
        end
        S_ARG: begin
          idx <= idx + 4'd1;
          if (upd) begin
            best_idx   <= idx;
            best_score <= score_in;
          end
          // Last index: fold this cycle's compare straight into the outputs.
          if (idx == 4'(NUM_CLASSES - 1)) begin
            state       <= S_DONE;
            class_id    <= upd ? idx : best_idx;
            class_score <= upd ? score_in : best_score;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lenet_layer_sequencer.sv
module tb_lenet_layer_sequencer;
  localparam int SW = 17;

  logic clk = 1'b0;
  logic rst, start;
  logic busy, done, error;
  logic [3:0] class_id, score_sel;
  logic signed [SW-1:0] class_score, score_in;
  logic conv1_start, conv2_start, conv3_start, fc_start;
  logic conv1_done, conv2_done, conv3_done, fc_done;

  always #5 clk = ~clk;

  lenet_layer_sequencer #(.bitwidth(9), .NUM_CLASSES(10), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
    .class_id(class_id), .class_score(class_score),
    .conv1_start(conv1_start), .conv2_start(conv2_start),
    .conv3_start(conv3_start), .fc_start(fc_start),
    .conv1_done(conv1_done), .conv2_done(conv2_done),
    .conv3_done(conv3_done), .fc_done(fc_done),
    .score_sel(score_sel), .score_in(score_in)
  );

  logic signed [SW-1:0] scores [10];
  assign score_in = (score_sel < 4'd10) ? scores[score_sel] : '0;

  int cyc = 0, base = 0;
  int lat [4];
  bit hold = 1'b0;
  int kc [4];
  int total = 0, bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  wire [3:0] kicks = {fc_start, conv3_start, conv2_start, conv1_start};
  wire [3:0] dn;
  assign {fc_done, conv3_done, conv2_done, conv1_done} = dn;

  // Stage engine models: done pulses lat[g] cycles after the kick (0 = never),
  // or sits high permanently while hold is set.
  for (genvar g = 0; g < 4; g++) begin : g_resp
    logic r;
    initial begin
      r = 1'b0;
      forever begin
        @(negedge clk);
        if (hold) r = 1'b1;
        else if (r) r = 1'b0;
        else if (kicks[g] && lat[g] != 0) begin
          repeat (lat[g]) @(negedge clk);
          r = 1'b1;
        end
      end
    end
    assign dn[g] = r;
  end

  always @(negedge clk)
    for (int k = 0; k < 4; k++) if (kicks[k]) kc[k] <= cyc - base;

  typedef struct {
    logic [3:0]           id;
    logic signed [SW-1:0] sc;
    int                   cy;
    logic                 err;
  } sb_t;
  sb_t sbq [$];
  logic [3:0]           last_id = 4'd0;
  logic signed [SW-1:0] last_sc = '0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference argmax: first strict maximum wins.
  task automatic model(output logic [3:0] id, output logic signed [SW-1:0] sc);
    id = 4'd0; sc = scores[0];
    for (int i = 1; i < 10; i++) if (scores[i] > sc) begin id = 4'(i); sc = scores[i]; end
  endtask

  task automatic launch(input bit push, input int exp_cy, input bit exp_err);
    sb_t e;
    @(negedge clk);
    start = 1'b1;
    base  = cyc;
    if (push) begin
      if (exp_err) begin e.id = last_id; e.sc = last_sc; end
      else begin model(e.id, e.sc); last_id = e.id; last_sc = e.sc; end
      e.cy = exp_cy; e.err = exp_err;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_cycle1", busy, 1);
    chk("conv1_start_cycle1", conv1_start, 1);
  endtask

  task automatic wait_done(input int budget, input int p1, input int p2);
    int  c;
    bit  seen;
    sb_t e;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      c = cyc - base;
      start = (c == p1) || (c == p2);
      if (done) begin
        seen = 1'b1;
        e = sbq.pop_front();
        chk("done_cycle", c, e.cy);
        chk("class_id", class_id, e.id);
        chk("class_score", class_score, e.sc);
        chk("error_at_done", error, e.err);
        chk("busy_at_done", busy, 0);
      end
    end
    chk("done_seen", seen, 1);
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit saw;
    rst = 1'b1; start = 1'b0;
    lat = '{1, 1, 1, 1};
    scores = '{-17'sd5, 17'sd3, 17'sd9, 17'sd9, 17'sd0, -17'sd256, 17'sd1, 17'sd2, 17'sd8, 17'sd7};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_kicks", kicks, 0);
    chk("rst_class_id", class_id, 0);
    chk("rst_class_score", class_score, 0);
    chk("rst_score_sel", score_sel, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic run, d=1 everywhere, tie between 2 and 3.
    launch(1, 19, 0);
    wait_done(100, -1, -1);
    chk("basic_kick_c2", kc[1], 3);
    chk("basic_kick_fc", kc[3], 7);

    // Varying latency.
    lat = '{7, 3, 12, 5};
    scores = '{17'sd12, -17'sd7, 17'sd100, -17'sd100, 17'sd255, 17'sd30, -17'sd1, 17'sd99, 17'sd100, 17'sd4};
    launch(1, 42, 0);
    wait_done(200, -1, -1);
    chk("var_kick_c1", kc[0], 1);
    chk("var_kick_c2", kc[1], 9);
    chk("var_kick_c3", kc[2], 13);
    chk("var_kick_fc", kc[3], 26);

    // Stale done held high; start poked while busy and in DONE.
    lat = '{1, 1, 1, 1};
    hold = 1'b1;
    @(negedge clk);
    launch(1, 19, 0);
    wait_done(100, 10, 19);
    chk("hold_kick_c2", kc[1], 3);
    chk("hold_kick_c3", kc[2], 5);
    chk("hold_kick_fc", kc[3], 7);
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) saw = 1'b1;
    end
    chk("no_second_run", saw, 0);
    hold = 1'b0;
    repeat (2) @(negedge clk);

    // All-negative scores.
    for (int i = 0; i < 9; i++) scores[i] = -17'sd65536;
    scores[9] = -17'sd65535;
    launch(1, 19, 0);
    wait_done(100, -1, -1);

    // Reset during C3, then a clean run.
    launch(0, 0, 0);
    repeat (4) @(negedge clk);
    chk("midrun_in_c3", conv3_start, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrun_busy", busy, 0);
    chk("midrun_done", done, 0);
    chk("midrun_kicks", kicks, 0);
    chk("midrun_class_id", class_id, 0);
    chk("midrun_class_score", class_score, 0);
    chk("midrun_score_sel", score_sel, 0);
    rst = 1'b0;
    last_id = 4'd0; last_sc = '0;
    repeat (5) @(negedge clk);
    scores = '{-17'sd5, 17'sd3, 17'sd9, 17'sd9, 17'sd0, -17'sd256, 17'sd1, 17'sd2, 17'sd8, 17'sd7};
    launch(1, 19, 0);
    wait_done(100, -1, -1);

`ifdef LENET_SEQ_TIMEOUT_EN
    // conv2 never finishes: abort, sticky error, class outputs kept.
    lat[1] = 0;
    launch(1, 19, 1);
    wait_done(100, -1, -1);
    chk("error_sticky", error, 1);
    lat[1] = 1;
    repeat (3) @(negedge clk);
    launch(1, 19, 0);
    chk("error_cleared_by_start", error, 0);
    wait_done(100, -1, -1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
